// File: rtl/stoch_im2col_pkg.sv
// Shared definitions for the stochastic im2col scheduler and im2col instances.
//   state_t  : sweep FSM state encoding
//   out_dim  : convolution output dimension for one axis
//   idx_w    : index width for a range of n values (minimum 1 bit)
package stoch_im2col_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned out_dim(input int unsigned im,
                                          input int unsigned pad,
                                          input int unsigned k,
                                          input int unsigned stride);
    return (im + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stoch_wrap_counter.sv
// Modulo counter with registered position flags.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (higher priority than en)
//   en       : advance by one, wrapping at MODULUS-1
//   count    : current value
//   first    : count == 0 (registered)
//   last     : count == MODULUS-1 (registered)
//   wrap     : en & last, i.e. this cycle wraps back to zero
module stoch_wrap_counter
  import stoch_im2col_pkg::*;
#(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WIDTH   = idx_w(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             first,
  output logic             last,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = count;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = last ? '0 : count + 1'b1;
  end

  assign wrap = en & last;

  // Flags track the next value so they stay aligned with count without decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      first <= 1'b1;
      last  <= (MAXV == '0);
    end else begin
      count <= nxt;
      first <= (nxt == '0);
      last  <= (nxt == MAXV);
    end
  end

endmodule

// File: rtl/stoch_im2col_scheduler.sv
// Sweeps every im2col patch of a padded/strided convolution, emitting
// NUM_SAMPLES stochastic bitstream beats per patch under valid/ready.
//   CLK, RST      : clock, synchronous active-high reset
//   start, abort  : begin sweep (IDLE only) / return to IDLE immediately
//   out_valid/out_ready : beat handshake
//   patch_idx     : orow*OUT_W+ocol
//   base_h/base_w : signed top-left input coordinate of the patch
//   sample_idx    : beat within the patch
//   first_sample, last_sample, last_patch : beat markers
//   busy, done    : in RUN / one-cycle completion pulse
module stoch_im2col_scheduler
  import stoch_im2col_pkg::*;
#(
  parameter int unsigned IM_HEIGHT   = 12,
  parameter int unsigned IM_WIDTH    = 12,
  parameter int unsigned KERNEL_H    = 3,
  parameter int unsigned KERNEL_W    = 3,
  parameter int unsigned PAD_H       = 2,
  parameter int unsigned PAD_W       = 2,
  parameter int unsigned STRIDE_H    = 1,
  parameter int unsigned STRIDE_W    = 1,
  parameter int unsigned NUM_SAMPLES = 256,
  localparam int unsigned OUT_H       = out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H),
  localparam int unsigned OUT_W       = out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W),
  localparam int unsigned NUM_PATCHES = OUT_H * OUT_W,
  localparam int unsigned PW          = idx_w(NUM_PATCHES),
  localparam int unsigned SW          = idx_w(NUM_SAMPLES),
  localparam int unsigned BHW = $clog2(((IM_HEIGHT > PAD_H) ? IM_HEIGHT : PAD_H) + 1) + 1,
  localparam int unsigned BWW = $clog2(((IM_WIDTH > PAD_W) ? IM_WIDTH : PAD_W) + 1) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         patch_idx,
  output logic signed [BHW-1:0] base_h,
  output logic signed [BWW-1:0] base_w,
  output logic [SW-1:0]         sample_idx,
  output logic                  first_sample,
  output logic                  last_sample,
  output logic                  last_patch,
  output logic                  busy,
  output logic                  done
);

  localparam int PAD_H_S = PAD_H;
  localparam int PAD_W_S = PAD_W;
  localparam logic signed [BHW-1:0] INIT_H = BHW'(-PAD_H_S);
  localparam logic signed [BWW-1:0] INIT_W = BWW'(-PAD_W_S);
  localparam logic signed [BHW-1:0] STEP_H = BHW'(STRIDE_H);
  localparam logic signed [BWW-1:0] STEP_W = BWW'(STRIDE_W);

  state_t state;
  logic   valid_q;
  logic   beat;
  logic   cnt_clr;
  logic   s_first, s_last, s_wrap;
  logic   c_first, c_last, c_wrap;
  logic   r_first, r_last, r_wrap;
  logic   p_first, p_last, p_wrap;
  logic [idx_w(OUT_W)-1:0] c_cnt;
  logic [idx_w(OUT_H)-1:0] r_cnt;
  logic   unused_cnt;

  assign beat    = valid_q & out_ready;
  // Counters sit at zero outside RUN, so a new sweep always starts from origin.
  assign cnt_clr = abort | (state != ST_RUN);

  stoch_wrap_counter #(.MODULUS(NUM_SAMPLES)) u_sample (
    .clk(CLK), .rst(RST), .clr(cnt_clr), .en(beat),
    .count(sample_idx), .first(s_first), .last(s_last), .wrap(s_wrap));

  stoch_wrap_counter #(.MODULUS(OUT_W)) u_col (
    .clk(CLK), .rst(RST), .clr(cnt_clr), .en(s_wrap),
    .count(c_cnt), .first(c_first), .last(c_last), .wrap(c_wrap));

  stoch_wrap_counter #(.MODULUS(OUT_H)) u_row (
    .clk(CLK), .rst(RST), .clr(cnt_clr), .en(c_wrap),
    .count(r_cnt), .first(r_first), .last(r_last), .wrap(r_wrap));

  stoch_wrap_counter #(.MODULUS(NUM_PATCHES)) u_patch (
    .clk(CLK), .rst(RST), .clr(cnt_clr), .en(s_wrap),
    .count(patch_idx), .first(p_first), .last(p_last), .wrap(p_wrap));

  assign unused_cnt = ^{c_cnt, r_cnt, c_first, r_first, p_first, r_wrap, p_wrap};

  always_ff @(posedge CLK) begin
    if (RST || abort) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      base_h  <= '0;
      base_w  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_RUN;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            base_h  <= INIT_H;
            base_w  <= INIT_W;
          end
        end
        ST_RUN: begin
          if (s_wrap) begin
            if (c_last && r_last) begin
              state   <= ST_DONE;
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              base_h  <= '0;
              base_w  <= '0;
            end else if (c_last) begin
              base_w <= INIT_W;
              base_h <= base_h + STEP_H;
            end else begin
              base_w <= base_w + STEP_W;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = valid_q;
  assign first_sample = valid_q & s_first;
  assign last_sample  = valid_q & s_last;
  assign last_patch   = valid_q & p_last;

endmodule
